ddr3_lane_read_train_ctrl: RTL and testbench

Per-lane read-training sequencer for the DDR3 PHY, one instance per DQ byte lane. It sits in the fabric in the FAB_CLK domain and drives the IOD input delay line (load/move/direction) and the eye-monitor flag clear. It sweeps the input delay taps, checks the 8-bit deserialised read data against the MPR training pattern, finds the first contiguous passing window and parks the delay at the window centre.

---
 rtl/ddr3_lane_read_train_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_ddr3_lane_read_train_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ddr3_lane_read_train_ctrl.sv
// Per-lane DDR3 read-training sequencer. It sweeps the IOD input delay against the MPR
// pattern, finds the first contiguous passing window, then parks the delay at the window centre.
module ddr3_lane_read_train_ctrl #(
  parameter int unsigned TAP_MAX       = 127,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned SAMPLE_CYCLES = 16,
  parameter logic [7:0]  EXP_PATTERN   = 8'h55,
  parameter bit          USE_EYE_MON   = 1'b1,
  parameter int unsigned MIN_WINDOW    = 4
) (
  input  logic       FAB_CLK,
  input  logic       ARST_N,
  input  logic       TRAIN_START,
  input  logic [7:0] RX_DATA,
  input  logic       EYE_MONITOR_EARLY,
  input  logic       EYE_MONITOR_LATE,
  input  logic       DELAY_LINE_OUT_OF_RANGE,
  output logic       DELAY_LINE_LOAD,
  output logic       DELAY_LINE_MOVE,
  output logic       DELAY_LINE_DIRECTION,
  output logic       EYE_MONITOR_CLEAR_FLAGS,
  output logic       BUSY,
  output logic       TRAIN_DONE,
  output logic       TRAIN_FAIL,
  output logic [7:0] TAP_VALUE,
  output logic [7:0] WINDOW_WIDTH
);

  localparam logic [7:0] TAP_MAX_L     = 8'(TAP_MAX);
  localparam logic [7:0] SETTLE_LAST   = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] SETTLE_L      = 8'(SETTLE_CYCLES);
  localparam logic [7:0] SAMPLE_LAST   = 8'(SAMPLE_CYCLES - 1);
  localparam logic [7:0] MIN_WINDOW_L  = 8'(MIN_WINDOW);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE,
    S_EVAL, S_STEP, S_CENTER, S_DONE, S_FAIL
  } state_t;

  state_t     state_q;
  logic [7:0] tap_q, first_q, last_q, target_q, width_q, cnt_q;
  logic       have_q, bad_q;
  logic       load_q, move_q, dir_q, clr_q, busy_q, done_q, fail_q;

  logic       sample_bad;
  logic       tap_pass;
  logic       have_d;
  logic       at_end;
  logic       close_win;
  logic [7:0] first_d, last_d, width_d, target_d;
  logic [8:0] sum_d;

  // Window bookkeeping as it will stand once the current tap's verdict is folded in.
  always_comb begin
    sample_bad = (RX_DATA != EXP_PATTERN) ||
                 (USE_EYE_MON && (EYE_MONITOR_EARLY || EYE_MONITOR_LATE));
    tap_pass   = ~bad_q;
    have_d     = have_q | tap_pass;
    first_d    = have_q ? first_q : tap_q;
    last_d     = tap_pass ? tap_q : last_q;
    width_d    = last_d - first_d + 8'd1;
    sum_d      = {1'b0, first_d} + {1'b0, last_d};
    target_d   = sum_d[8:1];
    at_end     = (tap_q == TAP_MAX_L) || DELAY_LINE_OUT_OF_RANGE;
    close_win  = (!tap_pass && have_q) || (at_end && have_d);
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q  <= S_IDLE;
      tap_q    <= '0;
      first_q  <= '0;
      last_q   <= '0;
      target_q <= '0;
      width_q  <= '0;
      cnt_q    <= '0;
      have_q   <= 1'b0;
      bad_q    <= 1'b0;
      load_q   <= 1'b0;
      move_q   <= 1'b0;
      dir_q    <= 1'b0;
      clr_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (TRAIN_START) begin
            state_q <= S_LOAD;
            load_q  <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            tap_q   <= '0;
            width_q <= '0;
            have_q  <= 1'b0;
          end
        end

        S_LOAD: begin
          load_q  <= 1'b0;
          clr_q   <= 1'b1;
          state_q <= S_CLEAR;
        end

        S_CLEAR: begin
          clr_q   <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_SETTLE;
        end

        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= '0;
            bad_q   <= 1'b0;
            state_q <= S_SAMPLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        S_SAMPLE: begin
          bad_q <= bad_q | sample_bad;
          if (cnt_q == SAMPLE_LAST) begin
            cnt_q   <= '0;
            state_q <= S_EVAL;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        S_EVAL: begin
          if (tap_pass) begin
            first_q <= first_d;
            last_q  <= last_d;
            have_q  <= 1'b1;
          end
          if (close_win) begin
            width_q <= width_d;
            if (width_d < MIN_WINDOW_L) begin
              state_q <= S_FAIL;
              fail_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              // Direction flips now so it leads the first decrement by a cycle.
              state_q  <= S_CENTER;
              target_q <= target_d;
              dir_q    <= 1'b0;
              cnt_q    <= SETTLE_L;
            end
          end else if (at_end) begin
            state_q <= S_FAIL;
            fail_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_STEP;
            move_q  <= 1'b1;
            dir_q   <= 1'b1;
            tap_q   <= tap_q + 8'd1;
          end
        end

        S_STEP: begin
          move_q  <= 1'b0;
          clr_q   <= 1'b1;
          state_q <= S_CLEAR;
        end

        // Walk back one tap at a time, letting the line settle between moves.
        S_CENTER: begin
          if (move_q) begin
            move_q <= 1'b0;
            cnt_q  <= '0;
          end else if (tap_q <= target_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (cnt_q >= SETTLE_L) begin
            move_q <= 1'b1;
            tap_q  <= tap_q - 8'd1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign DELAY_LINE_LOAD         = load_q;
  assign DELAY_LINE_MOVE         = move_q;
  assign DELAY_LINE_DIRECTION    = dir_q;
  assign EYE_MONITOR_CLEAR_FLAGS = clr_q;
  assign BUSY                    = busy_q;
  assign TRAIN_DONE              = done_q;
  assign TRAIN_FAIL              = fail_q;
  assign TAP_VALUE               = tap_q;
  assign WINDOW_WIDTH            = width_q;

endmodule

// File: tb/tb_ddr3_lane_read_train_ctrl.sv
// Directed bench for the lane read-training sequencer: a behavioural lane model
// returns the MPR pattern only on chosen taps; results are checked against hand-derived values.
module tb_ddr3_lane_read_train_ctrl;

  logic FAB_CLK = 1'b0;
  always #5 FAB_CLK = ~FAB_CLK;

  logic       ARST_N, TRAIN_START, early;
  logic [7:0] rx_a, rx_b;
  logic       late_a, late_b, oor_a, oor_b;
  logic       ld_a, mv_a, dir_a, clr_a, busy_a, done_a, fail_a;
  logic       ld_b, mv_b, dir_b, clr_b, busy_b, done_b, fail_b;
  logic [7:0] tap_a, width_a, tap_b, width_b;

  int lo, hi, oor_tap, eye_tap;
  int n_tests = 0, n_fail = 0;
  int loads = 0, incs = 0, decs = 0, overlaps = 0;

  assign rx_a   = (int'(tap_a) >= lo && int'(tap_a) <= hi) ? 8'h55 : 8'hA5;
  assign rx_b   = (int'(tap_b) >= lo && int'(tap_b) <= hi) ? 8'h55 : 8'hA5;
  assign late_a = (int'(tap_a) == eye_tap);
  assign late_b = (int'(tap_b) == eye_tap);
  assign oor_a  = (oor_tap >= 0) && (int'(tap_a) >= oor_tap);
  assign oor_b  = (oor_tap >= 0) && (int'(tap_b) >= oor_tap);

  ddr3_lane_read_train_ctrl u_dut_a (
    .FAB_CLK(FAB_CLK), .ARST_N(ARST_N), .TRAIN_START(TRAIN_START), .RX_DATA(rx_a),
    .EYE_MONITOR_EARLY(early), .EYE_MONITOR_LATE(late_a), .DELAY_LINE_OUT_OF_RANGE(oor_a),
    .DELAY_LINE_LOAD(ld_a), .DELAY_LINE_MOVE(mv_a), .DELAY_LINE_DIRECTION(dir_a),
    .EYE_MONITOR_CLEAR_FLAGS(clr_a), .BUSY(busy_a), .TRAIN_DONE(done_a), .TRAIN_FAIL(fail_a),
    .TAP_VALUE(tap_a), .WINDOW_WIDTH(width_a)
  );

  ddr3_lane_read_train_ctrl #(.USE_EYE_MON(1'b0)) u_dut_b (
    .FAB_CLK(FAB_CLK), .ARST_N(ARST_N), .TRAIN_START(TRAIN_START), .RX_DATA(rx_b),
    .EYE_MONITOR_EARLY(early), .EYE_MONITOR_LATE(late_b), .DELAY_LINE_OUT_OF_RANGE(oor_b),
    .DELAY_LINE_LOAD(ld_b), .DELAY_LINE_MOVE(mv_b), .DELAY_LINE_DIRECTION(dir_b),
    .EYE_MONITOR_CLEAR_FLAGS(clr_b), .BUSY(busy_b), .TRAIN_DONE(done_b), .TRAIN_FAIL(fail_b),
    .TAP_VALUE(tap_b), .WINDOW_WIDTH(width_b)
  );

  // Cumulative pulse counters for instance A; runs work on deltas.
  always @(posedge FAB_CLK) begin
    if (ld_a) loads++;
    if (mv_a && dir_a) incs++;
    if (mv_a && !dir_a) decs++;
    if (int'(ld_a) + int'(mv_a) + int'(clr_a) > 1) overlaps++;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int l0, i0, d0;

  task automatic run(input int lo_i, input int hi_i, input int oor_i, input int eye_i,
                     input bit mid_start, input string tag);
    bit finished;
    lo = lo_i; hi = hi_i; oor_tap = oor_i; eye_tap = eye_i;
    l0 = loads; i0 = incs; d0 = decs;
    @(negedge FAB_CLK) TRAIN_START = 1'b1;
    @(negedge FAB_CLK) TRAIN_START = 1'b0;
    check_eq({tag, "_busy"}, int'(busy_a), 1);
    check_eq({tag, "_load_first"}, int'(ld_a), 1);
    finished = 1'b0;
    for (int n = 0; n < 8000; n++) begin
      @(negedge FAB_CLK);
      if (mid_start && n == 500) TRAIN_START = 1'b1;
      else TRAIN_START = 1'b0;
      if ((done_a || fail_a) && (done_b || fail_b)) begin
        finished = 1'b1;
        break;
      end
    end
    TRAIN_START = 1'b0;
    check_eq({tag, "_finished"}, int'(finished), 1);
  endtask

  initial begin
    ARST_N = 1'b0; TRAIN_START = 1'b0; early = 1'b0;
    lo = 10; hi = 40; oor_tap = -1; eye_tap = -1;
    repeat (3) @(negedge FAB_CLK);
    check_eq("reset_outs", int'({ld_a, mv_a, dir_a, clr_a, busy_a, done_a, fail_a, tap_a, width_a}), 0);
    ARST_N = 1'b1;
    repeat (2) @(negedge FAB_CLK);

    // Window 10..40, with a stray start mid-sweep that must be ignored.
    run(10, 40, -1, -1, 1'b1, "w10_40");
    check_eq("w10_40_done", int'(done_a), 1);
    check_eq("w10_40_fail", int'(fail_a), 0);
    check_eq("w10_40_busy", int'(busy_a), 0);
    check_eq("w10_40_tap", int'(tap_a), 25);
    check_eq("w10_40_width", int'(width_a), 31);
    check_eq("w10_40_loads", loads - l0, 1);
    check_eq("w10_40_incs", incs - i0, 41);
    check_eq("w10_40_decs", decs - d0, 16);

    run(3, 5, -1, -1, 1'b0, "narrow");
    check_eq("narrow_fail", int'(fail_a), 1);
    check_eq("narrow_done", int'(done_a), 0);
    check_eq("narrow_width", int'(width_a), 3);
    check_eq("narrow_tap", int'(tap_a), 6);
    check_eq("narrow_decs", decs - d0, 0);

    run(200, -1, -1, -1, 1'b0, "nopass");
    check_eq("nopass_fail", int'(fail_a), 1);
    check_eq("nopass_tap", int'(tap_a), 127);
    check_eq("nopass_width", int'(width_a), 0);
    check_eq("nopass_incs", incs - i0, 127);

    run(100, 127, -1, -1, 1'b0, "top");
    check_eq("top_done", int'(done_a), 1);
    check_eq("top_tap", int'(tap_a), 113);
    check_eq("top_width", int'(width_a), 28);
    check_eq("top_decs", decs - d0, 14);

    run(100, 127, 110, -1, 1'b0, "oor");
    check_eq("oor_done", int'(done_a), 1);
    check_eq("oor_tap", int'(tap_a), 105);
    check_eq("oor_width", int'(width_a), 11);
    check_eq("oor_incs", incs - i0, 110);

    run(20, 30, -1, 25, 1'b0, "eye");
    check_eq("eye_on_done", int'(done_a), 1);
    check_eq("eye_on_tap", int'(tap_a), 22);
    check_eq("eye_on_width", int'(width_a), 5);
    check_eq("eye_off_tap", int'(tap_b), 25);
    check_eq("eye_off_width", int'(width_b), 11);

    // Reset during SAMPLE at tap 15, then retrain from scratch.
    lo = 10; hi = 40; oor_tap = -1; eye_tap = -1;
    @(negedge FAB_CLK) TRAIN_START = 1'b1;
    @(negedge FAB_CLK) TRAIN_START = 1'b0;
    begin
      bit hit;
      hit = 1'b0;
      for (int n = 0; n < 2000; n++) begin
        @(negedge FAB_CLK);
        if (tap_a == 8'd15) begin
          hit = 1'b1;
          break;
        end
      end
      check_eq("rst_reach_tap15", int'(hit), 1);
    end
    repeat (14) @(negedge FAB_CLK);
    #2 ARST_N = 1'b0;
    #1 check_eq("rst_mid_outs", int'({ld_a, mv_a, dir_a, clr_a, busy_a, done_a, fail_a, tap_a, width_a}), 0);
    @(negedge FAB_CLK) ARST_N = 1'b1;
    @(negedge FAB_CLK);
    run(10, 40, -1, -1, 1'b0, "rerun");
    check_eq("rerun_done", int'(done_a), 1);
    check_eq("rerun_tap", int'(tap_a), 25);
    check_eq("rerun_loads", loads - l0, 1);

    check_eq("pulse_overlap", overlaps, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
